// File: rtl/adf4030_trig_sched.sv
// adf4030_trig_sched: multi-channel trigger scheduler qualified by the ADF4030
// BSYNC strobe. A reference divider selects every (ref_div+1)th bsync; each
// channel waits for a qualified reference, delays by its phase, then emits a
// pulse of max(pulse_len,1) cycles in one-shot or periodic mode.
// Optional macro ADF4030_TRIG_TIMESTAMP_EN adds a reference timestamp/counter.
module adf4030_trig_sched #(
   parameter int unsigned CHANNEL_COUNT = 8,
   parameter int unsigned PHASE_WIDTH   = 16,
   parameter int unsigned PULSE_WIDTH   = 8,
   parameter int unsigned DIV_WIDTH     = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 bsync,
   input  logic                                 arm,
   input  logic [DIV_WIDTH-1:0]                 ref_div,
   input  logic [CHANNEL_COUNT-1:0]             ch_enable,
   input  logic [CHANNEL_COUNT-1:0]             ch_periodic,
   input  logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] ch_phase,
   input  logic [PULSE_WIDTH-1:0]               pulse_len,
   input  logic                                 clear_status,
   output logic [CHANNEL_COUNT-1:0]             trig_out,
   output logic                                 busy,
   output logic [CHANNEL_COUNT-1:0]             overrun,
   output logic [31:0]                          ref_timestamp,
   output logic [31:0]                          ref_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_REF,
      S_DELAY,
      S_PULSE
   } state_t;

   localparam logic [PHASE_WIDTH-1:0] PHASE_ONE = PHASE_WIDTH'(1);
   localparam logic [PULSE_WIDTH-1:0] PLEN_ONE  = PULSE_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0]     r_div_cnt;
   state_t                   r_state [CHANNEL_COUNT];
   logic [PHASE_WIDTH-1:0]   r_dly   [CHANNEL_COUNT];
   logic [PULSE_WIDTH-1:0]   r_plen  [CHANNEL_COUNT];
   logic [CHANNEL_COUNT-1:0] r_trig;
   logic [CHANNEL_COUNT-1:0] r_act;
   logic [CHANNEL_COUNT-1:0] r_armed;
   logic [CHANNEL_COUNT-1:0] r_ovr;
   logic                     w_ref_q;
   logic [PULSE_WIDTH-1:0]   w_plen_eff;
   logic [CHANNEL_COUNT-1:0] w_ovr_evt;

   assign w_ref_q    = bsync && (r_div_cnt == '0);
   assign w_plen_eff = (pulse_len == '0) ? PLEN_ONE : pulse_len;

   // Reference divider: qualifies a bsync when the count is zero, arm re-aligns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (arm) begin
         r_div_cnt <= '0;
      end else if (bsync) begin
         r_div_cnt <= (r_div_cnt == '0) ? ref_div : (r_div_cnt - DIV_ONE);
      end
   end

   // Overrun events: a reference landing in DELAY/PULSE, except on the final
   // cycle of a periodic pulse where the channel is about to rearm.
   always_comb begin
      w_ovr_evt = '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
         if (w_ref_q) begin
            case (r_state[i])
               S_DELAY: w_ovr_evt[i] = 1'b1;
               S_PULSE: w_ovr_evt[i] = !(ch_periodic[i] && (r_plen[i] == PLEN_ONE));
               default: w_ovr_evt[i] = 1'b0;
            endcase
         end
      end
   end

   // Per-channel FSMs with registered trigger, activity and sticky status bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            r_state[i] <= S_IDLE;
            r_dly[i]   <= '0;
            r_plen[i]  <= '0;
         end
         r_trig  <= '0;
         r_act   <= '0;
         r_armed <= '0;
         r_ovr   <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (w_ovr_evt[i]) begin
               r_ovr[i] <= 1'b1;
            end else if (clear_status) begin
               r_ovr[i] <= 1'b0;
            end

            if (!ch_enable[i]) begin
               r_state[i] <= S_IDLE;
               r_trig[i]  <= 1'b0;
               r_act[i]   <= 1'b0;
               r_armed[i] <= 1'b0;
            end else begin
               // Arm is consumed on leaving IDLE; an arm seen while the channel
               // is active therefore survives the return to IDLE and retriggers.
               if (arm) begin
                  r_armed[i] <= 1'b1;
               end
               case (r_state[i])
                  S_IDLE: begin
                     if (ch_periodic[i] || r_armed[i] || arm) begin
                        r_state[i] <= S_WAIT_REF;
                        r_armed[i] <= 1'b0;
                     end
                  end
                  S_WAIT_REF: begin
                     if (w_ref_q) begin
                        r_act[i] <= 1'b1;
                        if (ch_phase[i*PHASE_WIDTH +: PHASE_WIDTH] == '0) begin
                           r_state[i] <= S_PULSE;
                           r_plen[i]  <= w_plen_eff;
                           r_trig[i]  <= 1'b1;
                        end else begin
                           r_state[i] <= S_DELAY;
                           r_dly[i]   <= ch_phase[i*PHASE_WIDTH +: PHASE_WIDTH];
                        end
                     end
                  end
                  S_DELAY: begin
                     if (r_dly[i] == PHASE_ONE) begin
                        r_state[i] <= S_PULSE;
                        r_plen[i]  <= w_plen_eff;
                        r_trig[i]  <= 1'b1;
                     end else begin
                        r_dly[i] <= r_dly[i] - PHASE_ONE;
                     end
                  end
                  S_PULSE: begin
                     if (r_plen[i] == PLEN_ONE) begin
                        r_trig[i]  <= 1'b0;
                        r_act[i]   <= 1'b0;
                        r_state[i] <= ch_periodic[i] ? S_WAIT_REF : S_IDLE;
                     end else begin
                        r_plen[i] <= r_plen[i] - PLEN_ONE;
                     end
                  end
                  default: r_state[i] <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign trig_out = r_trig;
   assign busy     = |r_act;
   assign overrun  = r_ovr;

`ifdef ADF4030_TRIG_TIMESTAMP_EN
   logic [31:0] r_cyc;
   logic [31:0] r_ts;
   logic [31:0] r_rcnt;

   // Free-running cycle counter; capture it and count each qualified reference.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cyc  <= '0;
         r_ts   <= '0;
         r_rcnt <= '0;
      end else begin
         r_cyc <= r_cyc + 32'd1;
         if (w_ref_q) begin
            r_ts   <= r_cyc;
            r_rcnt <= r_rcnt + 32'd1;
         end
      end
   end

   assign ref_timestamp = r_ts;
   assign ref_count     = r_rcnt;
`else
   assign ref_timestamp = '0;
   assign ref_count     = '0;
`endif

endmodule

// File: tb/tb_adf4030_trig_sched.sv
// Scoreboard bench for adf4030_trig_sched: stimulus pushes expected pulses
// (channel, rise cycle, width); a monitor pops them as pulses complete.
module tb_adf4030_trig_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         bsync;
   logic         arm;
   logic [7:0]   ref_div;
   logic [7:0]   ch_enable;
   logic [7:0]   ch_periodic;
   logic [127:0] ch_phase;
   logic [7:0]   pulse_len;
   logic         clear_status;
   logic [7:0]   trig_out;
   logic         busy;
   logic [7:0]   overrun;
   logic [31:0]  ref_timestamp;
   logic [31:0]  ref_count;

   adf4030_trig_sched #(
      .CHANNEL_COUNT(8),
      .PHASE_WIDTH  (16),
      .PULSE_WIDTH  (8),
      .DIV_WIDTH    (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bsync        (bsync),
      .arm          (arm),
      .ref_div      (ref_div),
      .ch_enable    (ch_enable),
      .ch_periodic  (ch_periodic),
      .ch_phase     (ch_phase),
      .pulse_len    (pulse_len),
      .clear_status (clear_status),
      .trig_out     (trig_out),
      .busy         (busy),
      .overrun      (overrun),
      .ref_timestamp(ref_timestamp),
      .ref_count    (ref_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int rise;
      int width;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   t_bs;
   int   t_rel;
   logic [7:0] prev_trig = '0;
   int   rise_cyc[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: on each completed pulse, pop the matching expectation and compare.
   always @(negedge clk) begin
      for (int c = 0; c < 8; c++) begin
         if (trig_out[c] && !prev_trig[c]) begin
            rise_cyc[c] = cyc;
         end else if (!trig_out[c] && prev_trig[c]) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sbq.size(); k++) begin
               if (idx < 0 && sbq[k].ch == c) idx = k;
            end
            if (idx < 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse ch=%0d rise=%0d width=%0d required=none",
                        c, rise_cyc[c], cyc - rise_cyc[c]);
            end else begin
               chk($sformatf("pulse_rise_ch%0d", c), 64'(rise_cyc[c]), 64'(sbq[idx].rise));
               chk($sformatf("pulse_width_ch%0d", c), 64'(cyc - rise_cyc[c]), 64'(sbq[idx].width));
               sbq.delete(idx);
            end
         end
      end
      prev_trig = trig_out;
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input int rise, input int width);
      exp_t e;
      e.ch = ch;
      e.rise = rise;
      e.width = width;
      sbq.push_back(e);
   endtask

   task automatic do_bsync();
      bsync = 1'b1;
      t_bs  = cyc;
      step();
      bsync = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic set_phase(input int ch, input logic [15:0] v);
      ch_phase[ch*16 +: 16] = v;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; bsync = 1'b0; arm = 1'b0; ref_div = '0; ch_enable = '0;
      ch_periodic = '0; ch_phase = '0; pulse_len = '0; clear_status = 1'b0;
      step(3);
      chk("reset_trig", 64'(trig_out), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_overrun", 64'(overrun), 64'h0);
      rst = 1'b0;
      t_rel = cyc;
      step();
      chk("reset_ts", 64'(ref_timestamp), 64'h0);
      chk("reset_rcnt", 64'(ref_count), 64'h0);

      // ch0 periodic, phase 5, pulse 3, every bsync qualified
      ch_enable = 8'h01; ch_periodic = 8'h01; set_phase(0, 16'd5); pulse_len = 8'd3;
      step(3);
      for (int k = 0; k < 3; k++) begin
         do_bsync();
         push(0, t_bs + 6, 3);
         if (k == 0) chk("busy_delay", 64'(busy), 64'h1);
         step(39);
      end
      chk("idle_busy", 64'(busy), 64'h0);
      chk("ch0_overrun", 64'(overrun), 64'h0);
`ifdef ADF4030_TRIG_TIMESTAMP_EN
      chk("ts_count", 64'(ref_count), 64'd3);
      chk("ts_value", 64'(ref_timestamp), 64'(t_bs - t_rel));
`else
      chk("ts_count_off", 64'(ref_count), 64'h0);
      chk("ts_value_off", 64'(ref_timestamp), 64'h0);
`endif
      ch_enable = '0;
      step(2);

      // ref_div=2: ch1 one-shot (phase 4), ch3 periodic (phase 0) shows divider
      ref_div = 8'd2; ch_enable = 8'h0A; ch_periodic = 8'h08;
      set_phase(1, 16'd4); set_phase(3, 16'd0); pulse_len = 8'd2;
      step(2);
      do_arm();
      step(2);
      for (int k = 0; k < 6; k++) begin
         do_bsync();
         if (k == 0) begin
            push(1, t_bs + 5, 2);
            push(3, t_bs + 1, 2);
         end
         if (k == 3) push(3, t_bs + 1, 2);
         step(14);
      end
      chk("oneshot_busy_after", 64'(busy), 64'h0);
      chk("oneshot_overrun", 64'(overrun), 64'h0);
      ch_enable = '0;
      step(2);

      // ch2 periodic, phase 30, bsync every 10 cycles -> overrun, period 40
      ref_div = 8'd0; ch_enable = 8'h04; ch_periodic = 8'h04;
      set_phase(2, 16'd30); pulse_len = 8'd3;
      step(2);
      do_arm();
      step(2);
      for (int k = 0; k < 9; k++) begin
         if (k == 6) clear_status = 1'b1;
         do_bsync();
         clear_status = 1'b0;
         if (k == 0 || k == 4 || k == 8) push(2, t_bs + 31, 3);
         if (k == 0) chk("ovr_initial", 64'(overrun), 64'h0);
         if (k == 1) chk("ovr_set", 64'(overrun), 64'h04);
         if (k == 5) chk("ovr_reset_again", 64'(overrun), 64'h04);
         if (k == 6) chk("ovr_set_wins", 64'(overrun), 64'h04);
         if (k == 4) begin
            step(3);
            clear_status = 1'b1;
            step();
            clear_status = 1'b0;
            chk("ovr_cleared", 64'(overrun), 64'h0);
            step(5);
         end else begin
            step(9);
         end
      end
      step(30);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      ch_enable = '0;
      step(2);

      // ch4: phase 0 with pulse_len 0, then maximum phase
      ch_enable = 8'h10; ch_periodic = 8'h10; set_phase(4, 16'd0); pulse_len = 8'd0;
      step(2);
      do_bsync();
      push(4, t_bs + 1, 1);
      step(10);
      set_phase(4, 16'hFFFF); pulse_len = 8'd1;
      do_bsync();
      push(4, t_bs + 65536, 1);
      step(100);
      chk("maxphase_busy", 64'(busy), 64'h1);
      chk("maxphase_overrun", 64'(overrun), 64'h0);
      step(65440);
      ch_enable = '0;
      step(2);

      // ch5: enable dropped mid-PULSE truncates the pulse
      ch_enable = 8'h20; ch_periodic = 8'h20; set_phase(5, 16'd2); pulse_len = 8'd6;
      step(2);
      do_bsync();
      push(5, t_bs + 3, 2);
      step(3);
      chk("pulse_high_ch5", 64'(trig_out), 64'h20);
      ch_enable = '0;
      step();
      chk("disable_trig", 64'(trig_out), 64'h0);
      chk("disable_busy", 64'(busy), 64'h0);
      step(5);

      // ch6: reset asserted mid-DELAY; nothing afterwards
      ch_enable = 8'h40; ch_periodic = 8'h40; set_phase(6, 16'd20); pulse_len = 8'd2;
      step(2);
      do_bsync();
      step(4);
      chk("rst_pre_busy", 64'(busy), 64'h1);
      rst = 1'b1;
      step();
      chk("rst_trig", 64'(trig_out), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_overrun", 64'(overrun), 64'h0);
      chk("rst_ts", 64'(ref_timestamp), 64'h0);
      chk("rst_rcnt", 64'(ref_count), 64'h0);
      rst = 1'b0;
      step(40);
      chk("rst_no_pulse_busy", 64'(busy), 64'h0);

      step(5);
      chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
